pipeline_hazard_ctrl: RTL and testbench

Central hazard sequencer for the 5-stage MIPS pipeline. Each cycle it detects load-use, taken-branch, jump and memory-stall hazards and drives the control codes for the PC register, the IF/ID register (clear/load/hold plus delay) and the ID/EX register (flush). A small state machine stretches taken-branch recovery into a two-cycle flush, so redirected fetch never lands in IF/ID early.

---
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use, taken-branch, jump and memory-stall control.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles/flush_cycles counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             mem_stall,
    output logic             pc_write,
    output logic [1:0]       if_id_ctrl,
    output logic             hazard_delay,
    output logic             id_ex_flush,
    output logic [1:0]       ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        BR_FLUSH = 2'b10,
        BR_DELAY = 2'b11
    } state_t;

    localparam logic [1:0] IFID_CLEAR = 2'b00;
    localparam logic [1:0] IFID_LOAD  = 2'b01;
    localparam logic [1:0] IFID_HOLD  = 2'b10;

    state_t state_q, state_d;
    logic   load_use;

    // A load into $zero never produces a real dependency.
    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b1;
        if_id_ctrl   = IFID_LOAD;
        hazard_delay = 1'b0;
        id_ex_flush  = 1'b0;
        if (mem_stall) begin
            pc_write   = 1'b0;
            if_id_ctrl = IFID_HOLD;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_ctrl  = IFID_CLEAR;
                        id_ex_flush = 1'b1;
                        state_d     = BR_FLUSH;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_ctrl  = IFID_HOLD;
                        id_ex_flush = 1'b1;
                        state_d     = LU_STALL;
                    end else if (id_jump) begin
                        if_id_ctrl = IFID_CLEAR;
                    end
                end
                // The stalled load is now in MEM and covered by forwarding; a
                // newly arrived load is re-checked once back in RUN.
                LU_STALL: begin
                    if (id_jump) begin
                        if_id_ctrl = IFID_CLEAR;
                    end
                    state_d = RUN;
                end
                BR_FLUSH: begin
                    pc_write    = 1'b0;
                    if_id_ctrl  = IFID_CLEAR;
                    id_ex_flush = 1'b1;
                    state_d     = BR_DELAY;
                end
                BR_DELAY: begin
                    hazard_delay = 1'b1;
                    if_id_ctrl   = IFID_CLEAR;
                    id_ex_flush  = 1'b1;
                    state_d      = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (if_id_ctrl == IFID_HOLD) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (id_ex_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: checks output/state vectors against hand-computed values.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, ex_mem_read;
    logic       ex_branch_taken, id_jump, mem_stall;
    logic       pc_write, hazard_delay, id_ex_flush;
    logic [1:0] if_id_ctrl, ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.REG_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .id_jump         (id_jump),
        .mem_stall       (mem_stall),
        .pc_write        (pc_write),
        .if_id_ctrl      (if_id_ctrl),
        .hazard_delay    (hazard_delay),
        .id_ex_flush     (id_ex_flush),
        .ctrl_state      (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Vector layout: {pc_write, if_id_ctrl, hazard_delay, id_ex_flush, ctrl_state}
    task automatic check(input string tag, input logic pw, input logic [1:0] ic,
                         input logic hd, input logic fl, input logic [1:0] st);
        logic [6:0] obs, exp;
        obs = {pc_write, if_id_ctrl, hazard_delay, id_ex_flush, ctrl_state};
        exp = {pw, ic, hd, fl, st};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
        ex_branch_taken = 0; id_jump = 0; mem_stall = 0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #2;
        check("reset_state", 1, 2'b01, 0, 0, 2'b00);
        #10 reset = 1'b0;
        #1;
        check("run_normal", 1, 2'b01, 0, 0, 2'b00);

        // Load-use on Rs
        ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
        #1 check("lu_detect", 0, 2'b10, 0, 1, 2'b00);
        tick();
        check("lu_stall_ignores_new_lu", 1, 2'b01, 0, 0, 2'b01);
        clear_inputs();
        tick();
        check("lu_back_to_run", 1, 2'b01, 0, 0, 2'b00);

        // Load-use on Rt only when id_uses_rt
        ex_mem_read = 1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 0;
        #1 check("rt_match_unused", 1, 2'b01, 0, 0, 2'b00);
        id_uses_rt = 1;
        #1 check("rt_match_used", 0, 2'b10, 0, 1, 2'b00);
        tick();
        clear_inputs();
        tick();
        check("rt_lu_recovered", 1, 2'b01, 0, 0, 2'b00);

        // Taken branch: 00 -> 10 -> 11 -> 00, jump ignored during flush
        ex_branch_taken = 1;
        #1 check("br_redirect", 1, 2'b00, 0, 1, 2'b00);
        tick();
        ex_branch_taken = 0; id_jump = 1;
        #1 check("br_flush", 0, 2'b00, 0, 1, 2'b10);
        tick();
        id_jump = 0;
        #1 check("br_delay", 1, 2'b00, 1, 1, 2'b11);
        tick();
        check("br_done", 1, 2'b01, 0, 0, 2'b00);

        // Plain jump
        id_jump = 1;
        #1 check("jump", 1, 2'b00, 0, 0, 2'b00);
        tick();
        check("jump_stays_run", 1, 2'b00, 0, 0, 2'b00);
        clear_inputs();

        // Jump plus load-use: load-use wins, jump served next cycle
        id_jump = 1; ex_mem_read = 1; ex_rt = 5'd3; id_rs = 5'd3; id_uses_rs = 1;
        #1 check("jump_lu_lu_wins", 0, 2'b10, 0, 1, 2'b00);
        tick();
        ex_mem_read = 0;
        #1 check("jump_after_lu", 1, 2'b00, 0, 0, 2'b01);
        tick();
        clear_inputs();
        #1 check("jump_lu_done", 1, 2'b01, 0, 0, 2'b00);

        // mem_stall outranks a branch in RUN
        mem_stall = 1; ex_branch_taken = 1;
        #1 check("stall_over_branch", 0, 2'b10, 0, 0, 2'b00);
        tick();
        check("stall_holds_run", 0, 2'b10, 0, 0, 2'b00);
        clear_inputs();

        // mem_stall for 3 cycles in BR_FLUSH
        ex_branch_taken = 1;
        #1;
        tick();
        ex_branch_taken = 0; mem_stall = 1;
        #1 check("brf_stall_c1", 0, 2'b10, 0, 0, 2'b10);
        tick();
        check("brf_stall_c2", 0, 2'b10, 0, 0, 2'b10);
        tick();
        check("brf_stall_c3", 0, 2'b10, 0, 0, 2'b10);
        tick();
        mem_stall = 0;
        #1 check("brf_release", 0, 2'b00, 0, 1, 2'b10);
        tick();
        check("brf_then_delay", 1, 2'b00, 1, 1, 2'b11);
        tick();
        check("brf_then_run", 1, 2'b01, 0, 0, 2'b00);

        // Load into $zero never stalls
        ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
        id_rt = 5'd0; id_uses_rt = 1;
        #1 check("ex_rt_zero", 1, 2'b01, 0, 0, 2'b00);
        tick();
        check("ex_rt_zero_state", 1, 2'b01, 0, 0, 2'b00);
        clear_inputs();

        // Asynchronous reset in BR_DELAY
        ex_branch_taken = 1;
        #1;
        tick();
        ex_branch_taken = 0;
        tick();
        check("pre_reset_delay", 1, 2'b00, 1, 1, 2'b11);
        #2 reset = 1'b1;
        #1 check("reset_in_delay", 1, 2'b01, 0, 0, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert ({stall_cycles, flush_cycles} === 64'd0) else begin
            failures++;
            $error("FAIL perf_reset observed=%h/%h expected=0/0", stall_cycles, flush_cycles);
        end
`endif
        tick();
        reset = 1'b0;
        #1 check("after_reset_run", 1, 2'b01, 0, 0, 2'b00);
        tick();
        check("no_flush_resume", 1, 2'b01, 0, 0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
